u_idu_inst_buffer: RTL
======================

// Module: u_idu_inst_buffer
// PURPOSE
// - Dual-issue instruction buffer at the IDU front. Sits directly downstream of the IFU.
// - Each cycle that ifu_idu_pipe_vld is high, it accepts two fetched instructions (pc/inst/unalign per slot).
// - It presents the two oldest entries to the IDU decoders and drains 0..2 per cycle.
// - It drives the instBuffer_full back-pressure that the IFU uses to hold its PC.
// PARAMETERS
// - DEPTH      8   entry count; power of 2, >= 4.
// - PTR_W      3   log2(DEPTH).
// - `PC_WIDTH / `INST_WIDTH   project-wide widths from the shared defines file.
// PORTS
// - clk                    in   1            core clock; one clock, all logic posedge
// - rst                    in   1            reset is synchronous and active-high
// - sync_start_pulse       in   1            synchronized core start; clears buffer
// - iex_ifu_bru_flush      in   1            BRU mispredict flush; clears buffer
// - ifu_idu_pipe_vld       in   1            enqueue both fetch slots this cycle
// - ifu_idu_pc_1/_2        in   PC_WIDTH     slot pcs (slot 1 older)
// - ifu_idu_inst_1/_2      in   INST_WIDTH   slot instructions
// - ifu_idu_pc_unalign_1/_2 in  1            slot pc-misalign flags
// - dec_deq_num            in   2            entries consumed by decode this cycle (0,1,2)
// - idu_ifu_instBuffer_full out 1            fewer than 2 free entries
// - ibuf_dec_vld_1/_2      out  1            head / head+1 entry valid
// - ibuf_dec_pc_1/_2       out  PC_WIDTH     head / head+1 pc
// - ibuf_dec_inst_1/_2     out  INST_WIDTH   head / head+1 instruction
// - ibuf_dec_unalign_1/_2  out  1            head / head+1 misalign flag
// BEHAVIOUR
// - State: entry array[DEPTH] {pc, inst, unalign}; wr_ptr, rd_ptr (PTR_W bits, wrap mod DEPTH); cnt (PTR_W+1 bits, 0..DEPTH).
// - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, cnt=0.
//   - Outputs after reset: full=0, vld_1=vld_2=0, pc/inst/unalign=0. Entry array is not reset.
// - Clear (sync_start_pulse | iex_ifu_bru_flush):
//   - Same effect as reset on the next edge.
//   - Overrides enqueue and dequeue in the same cycle. Priority: rst > clear > enq/deq.
// - Enqueue: pipe_vld=1 and full=0.
//   - Slot 1 is written at wr_ptr, slot 2 at wr_ptr+1. wr_ptr += 2.
//   - pipe_vld=1 while full=1 is a protocol error: the write is dropped and cnt is unchanged.
// - Dequeue: rd_ptr += deq_eff, where deq_eff = min(dec_deq_num, cnt).
//   - dec_deq_num=3 is treated as 2.
//   - Over-request is clamped; the pointer never passes wr_ptr.
// - cnt_next = cnt + (enq ? 2 : 0) - deq_eff. Simultaneous enq+deq is legal in every state, including cnt=DEPTH-2 with deq=2.
// - full = (cnt > DEPTH-2), combinational from the cnt register only. It has no path from pipe_vld or dec_deq_num, which avoids a loop through the IFU pipe_vld.
//   - Dequeue credit takes effect one cycle later. Conservative by design.
// - Read side is combinational from rd_ptr, so an entry is visible the cycle after it is enqueued (1-cycle latency, no bypass).
//   - vld_1 = (cnt>=1); vld_2 = (cnt>=2).
//   - Data ports read entry[rd_ptr] and entry[rd_ptr+1]. Data is forced to 0 when the matching vld is 0.
// - Wrap-around: pointers are modulo DEPTH.
//   - A slot pair may straddle the wrap (wr_ptr=DEPTH-1 → slot 2 at index 0).
//   - Read pairs may straddle the same way.
// - Order: slot 1 is always older than slot 2. Program order is preserved FIFO.
// - Boundaries:
//   - cnt=0: nothing valid; deq ignored.
//   - cnt=1: only vld_1; deq 2 → deq_eff 1.
//   - cnt=DEPTH: full; enqueue blocked.
// - Reset mid-operation: all contents are discarded. No partial state survives; the next enq lands at index 0.
// STRUCTURE
// - Shared defines file: `PC_WIDTH, `INST_WIDTH, new `IBUF_DEPTH (8) and `IBUF_PTR_W (3).
// - The entry struct width (PC_WIDTH+INST_WIDTH+1) is a local constant.
// - One sub-module: u_idu_ibuf_regfile. It is a DEPTH x entry storage with 2 write ports (wr_ptr, wr_ptr+1, shared we) and 2 async read ports. It has no reset.
// - Pointer/count control and the output muxing stay in the top module.
// TESTING
// - Reset, then idle: full=0, vld_1=vld_2=0, all data outputs 0 for 5 cycles.
// - Fill: pipe_vld 1 cycle, pc 0x100/0x104, deq=0.
//   - Next cycle vld_1=vld_2=1, pc_1=0x100, pc_2=0x104.
//   - After 4 pairs, cnt=8 and full=1 on the following cycle.
//   - A 5th enqueue attempt is dropped.
// - Drain and wrap: from full (8), deq=2 with an enq each cycle for 6 cycles.
//   - Entries come out strictly in pc order 0x100,0x104,...
//   - A pair straddles index 7→0 correctly.
// - Flush collision: cnt=4; pipe_vld=1, deq=2 and iex_ifu_bru_flush=1 in the same cycle.
//   - Next cycle cnt=0, vld_1=0, full=0.
//   - A following enq of pc 0x200 appears at pc_1 next cycle.
// - Over-dequeue: cnt=1 and deq=2 → cnt=0, rd_ptr advanced by 1. A later enq is read back correctly.
// - Misalign propagation: enq with unalign_1=1, pc_1=0x102. Next cycle ibuf_dec_unalign_1=1, unalign_2=0.

Source files
------------

// File: rtl/u_idu_inst_buffer_pkg.sv
// Shared IDU instruction-buffer widths, entry layout and dequeue helper.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef IBUF_DEPTH
`define IBUF_DEPTH 8
`endif
`ifndef IBUF_PTR_W
`define IBUF_PTR_W 3
`endif

package u_idu_inst_buffer_pkg;

  localparam int unsigned PC_W       = `PC_WIDTH;
  localparam int unsigned INST_W     = `INST_WIDTH;
  localparam int unsigned IBUF_DEPTH = `IBUF_DEPTH;
  localparam int unsigned IBUF_PTR_W = `IBUF_PTR_W;
  localparam int unsigned ENTRY_W    = PC_W + INST_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              unalign;
  } ibuf_entry_t;

  // Decode request normalised to 0..2; an encoding of 3 counts as 2.
  function automatic logic [1:0] deq_req(input logic [1:0] num);
    logic [1:0] r;
    r = (num == 2'd3) ? 2'd2 : num;
    return r;
  endfunction

endpackage

// File: rtl/u_idu_ibuf_regfile.sv
// DEPTH x entry storage: one write enable, two adjacent write slots, two async reads.
module u_idu_ibuf_regfile
  import u_idu_inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = IBUF_DEPTH,
  parameter int unsigned PTR_W = IBUF_PTR_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_ptr,
  input  ibuf_entry_t      wdata_1,
  input  ibuf_entry_t      wdata_2,
  input  logic [PTR_W-1:0] rd_ptr_1,
  input  logic [PTR_W-1:0] rd_ptr_2,
  output ibuf_entry_t      rdata_1,
  output ibuf_entry_t      rdata_2
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  ibuf_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_2;

  // Slot 2 lands one index above slot 1, wrapping naturally at DEPTH.
  assign wr_ptr_2 = wr_ptr + PTR_ONE;

  // Pair write; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr]   <= wdata_1;
      mem[wr_ptr_2] <= wdata_2;
    end
  end

  assign rdata_1 = mem[rd_ptr_1];
  assign rdata_2 = mem[rd_ptr_2];

endmodule

// File: rtl/u_idu_inst_buffer.sv
// Dual-issue IDU instruction buffer: 2-wide enqueue from IFU, 0..2 drain to decode.
module u_idu_inst_buffer
  import u_idu_inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = IBUF_DEPTH,
  parameter int unsigned PTR_W = IBUF_PTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync_start_pulse,
  input  logic              iex_ifu_bru_flush,
  input  logic              ifu_idu_pipe_vld,
  input  logic [PC_W-1:0]   ifu_idu_pc_1,
  input  logic [PC_W-1:0]   ifu_idu_pc_2,
  input  logic [INST_W-1:0] ifu_idu_inst_1,
  input  logic [INST_W-1:0] ifu_idu_inst_2,
  input  logic              ifu_idu_pc_unalign_1,
  input  logic              ifu_idu_pc_unalign_2,
  input  logic [1:0]        dec_deq_num,
  output logic              idu_ifu_instBuffer_full,
  output logic              ibuf_dec_vld_1,
  output logic              ibuf_dec_vld_2,
  output logic [PC_W-1:0]   ibuf_dec_pc_1,
  output logic [PC_W-1:0]   ibuf_dec_pc_2,
  output logic [INST_W-1:0] ibuf_dec_inst_1,
  output logic [INST_W-1:0] ibuf_dec_inst_2,
  output logic              ibuf_dec_unalign_1,
  output logic              ibuf_dec_unalign_2
);

  localparam logic [PTR_W:0]   FULL_TH = (PTR_W+1)'(DEPTH - 2);
  localparam logic [PTR_W:0]   CNT_TWO = (PTR_W+1)'(2);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_TWO = PTR_W'(2);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_2;
  logic [PTR_W:0]   cnt;
  logic [PTR_W:0]   deq_want;
  logic [PTR_W:0]   deq_eff;
  logic             clear;
  logic             enq;
  ibuf_entry_t      wdata_1;
  ibuf_entry_t      wdata_2;
  ibuf_entry_t      rdata_1;
  ibuf_entry_t      rdata_2;

  // Full looks only at the registered count so it never depends on pipe_vld.
  assign idu_ifu_instBuffer_full = (cnt > FULL_TH);

  assign clear = sync_start_pulse | iex_ifu_bru_flush;
  assign enq   = ifu_idu_pipe_vld & ~idu_ifu_instBuffer_full;

  // Clamp the decode request to what is actually held.
  always_comb begin
    deq_want = (PTR_W+1)'(deq_req(dec_deq_num));
    deq_eff  = (deq_want > cnt) ? cnt : deq_want;
  end

  // Pointer and occupancy update; reset and clear override any enq/deq.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_TWO;
      end
      rd_ptr <= rd_ptr + deq_eff[PTR_W-1:0];
      cnt    <= cnt + (enq ? CNT_TWO : '0) - deq_eff;
    end
  end

  assign wdata_1  = '{pc: ifu_idu_pc_1, inst: ifu_idu_inst_1, unalign: ifu_idu_pc_unalign_1};
  assign wdata_2  = '{pc: ifu_idu_pc_2, inst: ifu_idu_inst_2, unalign: ifu_idu_pc_unalign_2};
  assign rd_ptr_2 = rd_ptr + PTR_ONE;

  u_idu_ibuf_regfile #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_regfile (
    .clk      (clk),
    .we       (enq & ~clear & ~rst),
    .wr_ptr   (wr_ptr),
    .wdata_1  (wdata_1),
    .wdata_2  (wdata_2),
    .rd_ptr_1 (rd_ptr),
    .rd_ptr_2 (rd_ptr_2),
    .rdata_1  (rdata_1),
    .rdata_2  (rdata_2)
  );

  // Head pair presentation; data is zeroed whenever its valid is low.
  always_comb begin
    ibuf_dec_vld_1     = (cnt != '0);
    ibuf_dec_vld_2     = (cnt >= CNT_TWO);
    ibuf_dec_pc_1      = ibuf_dec_vld_1 ? rdata_1.pc      : '0;
    ibuf_dec_inst_1    = ibuf_dec_vld_1 ? rdata_1.inst    : '0;
    ibuf_dec_unalign_1 = ibuf_dec_vld_1 ? rdata_1.unalign : 1'b0;
    ibuf_dec_pc_2      = ibuf_dec_vld_2 ? rdata_2.pc      : '0;
    ibuf_dec_inst_2    = ibuf_dec_vld_2 ? rdata_2.inst    : '0;
    ibuf_dec_unalign_2 = ibuf_dec_vld_2 ? rdata_2.unalign : 1'b0;
  end

endmodule
